load_ext_pipe: RTL and testbench
================================

Name: load_ext_pipe

Overview:
- Parametrised successor to the 16-to-32 immediate sign/zero extender, placed in the MEM/WB path of the pipeline CPU.
- Takes a raw memory read word plus the low address bits and a load mode. Selects the byte, half or word lane, then sign- or zero-extends it to DATA_W.
- Flags misaligned or illegal accesses.
- Carries the result through a STAGES-deep elastic pipeline with valid/ready handshake, flush, and a saturating error counter.

Parameters:
- DATA_W, 32, datapath width. Legal values are 32 and 64. Little-endian lanes.
- STAGES, 1, number of register stages between input and output. Legal range 1..3.
- TAG_W, 5, width of the sideband tag (destination register number) carried alongside the data.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline clear (branch/exception kill).
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- rdata  in  DATA_W  raw aligned memory read word.
- addr_lo  in  AW  byte offset within word, where AW = log2(DATA_W/8), i.e. 2 or 3.
- mode  in  3  load mode, encoded as:
  - 000 LB (byte, sign-extended)
  - 001 LH (half, sign-extended)
  - 010 LW (word, sign-extended to DATA_W)
  - 011 LD (doubleword; legal only when DATA_W=64)
  - 100 LBU (byte, zero-extended)
  - 101 LHU (half, zero-extended)
  - 110 LWU (word, zero-extended)
  - 111 reserved
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  DATA_W  extended result.
- out_err  out  1  beat is misaligned or illegal.
- out_tag  out  TAG_W  tag delivered with the beat.
- err_cnt  out  CNT_W  saturating count of error beats accepted.

Behaviour:
- Reset (rst=1 at a clk edge): every stage valid bit, data register, err bit and tag register clears to 0, and err_cnt clears to 0. After reset, out_valid=0, out_data=0, out_err=0, out_tag=0, err_cnt=0. rst has priority over all other inputs, including a transfer in progress.
- Extension is combinational on the input side and is registered into stage 1.
  - Lane select for a byte: rdata[8*addr_lo +: 8].
  - Lane select for a half: rdata[8*addr_lo +: 16].
  - Lane select for a word: rdata[8*addr_lo +: 32].
  - Signed modes replicate the lane MSB up to DATA_W-1. Unsigned modes fill the upper bits with 0.
  - LD passes the full 64 bits.
  - For DATA_W=32, LW and LWU produce identical results.
- Error conditions (err=1, data forced to 0, tag still carried):
  - Half mode with addr_lo[0]=1.
  - Word mode with addr_lo[1:0]!=0.
  - LD with addr_lo!=0.
  - LD when DATA_W=32.
  - mode=111.
- Pipeline stall and handshake:
  - Define the global enable en = out_ready | ~out_valid.
  - in_ready = en & ~flush.
  - When en=1, every stage shifts forward by one. Stage 1 loads (in_valid & in_ready) together with the extended data, err and tag.
  - When en=0, all stages hold.
  - Bubbles are not compressed.
  - Latency is exactly STAGES cycles from acceptance to out_valid when out_ready stays 1.
- Outputs are stable while out_valid=1 and out_ready=0.
- Flush: all valid bits clear at the edge, regardless of en. No beat is accepted that cycle. Data and tag registers may keep stale values, but out_data, out_err and out_tag must read 0 whenever out_valid=0.
- err_cnt increments by 1 on each accepted input beat with err=1, counted at acceptance rather than at output. It saturates at 2^CNT_W-1. Flush does not clear err_cnt; only rst does.
- Simultaneous rst and flush: rst wins, with identical effect.

Test Plan:
- DATA_W=32, STAGES=1, out_ready=1, rdata=0x80FF7F01, mode=000, addr_lo=1 -> one cycle later out_data=0x0000007F, out_err=0. Same input with addr_lo=3 -> out_data=0xFFFFFF80. With mode=100, addr_lo=3 -> out_data=0x00000080.
- rdata=0x8001ABCD, mode=001, addr_lo=2 -> out_data=0xFFFF8001. Same with mode=101 -> 0x00008001. mode=001, addr_lo=1 -> out_err=1, out_data=0, err_cnt increments to 1.
- DATA_W=64, rdata=0x89ABCDEF01234567: mode=010, addr_lo=4 -> 0xFFFFFFFF89ABCDEF. mode=110, addr_lo=4 -> 0x0000000089ABCDEF. mode=011, addr_lo=0 -> passthrough. mode=011, addr_lo=4 -> err.
- STAGES=3, stream 5 beats with tags 1..5, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 while full-stalled, outputs stable throughout, tags emerge 1..5 in order with no loss or duplication.
- STAGES=2, 2 beats in flight, assert flush for one cycle with in_valid=1 -> out_valid=0 the next cycle, in_ready=0 during the flush, the flushed beats never appear, err_cnt unchanged.
- CNT_W=2, drive 5 erroring beats (mode=111) -> err_cnt reads 1, 2, 3, 3, 3. Assert rst mid-stream -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/load_ext_pipe.sv
// Load-data extender for the MEM/WB path: lane select, sign/zero extension and
// alignment checking, followed by a STAGES-deep elastic valid/ready pipeline.
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 8,
  localparam int AW    = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [AW-1:0]     addr_lo,
  input  logic [2:0]        mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  localparam logic [DATA_W-1:0] KEEP_B = DATA_W'({8{1'b1}});
  localparam logic [DATA_W-1:0] KEEP_H = DATA_W'({16{1'b1}});
  localparam logic [DATA_W-1:0] KEEP_W = DATA_W'({32{1'b1}});

  size_e              sz;
  logic               uns;
  logic [DATA_W-1:0]  lane;
  logic [DATA_W-1:0]  keep;
  logic               sign;
  logic [DATA_W-1:0]  ext_data;
  logic               ext_err;

  logic               en;
  logic               accept;

  logic [STAGES-1:0]  vld_q;
  logic [DATA_W-1:0]  data_q [STAGES];
  logic               err_q  [STAGES];
  logic [TAG_W-1:0]   tag_q  [STAGES];
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;

  assign sz   = size_e'(mode[1:0]);
  assign uns  = mode[2];
  // Shifting by the byte offset puts the selected lane at bit 0 for every size.
  assign lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    keep     = KEEP_B;
    sign     = lane[7];
    ext_err  = 1'b0;
    ext_data = '0;
    case (sz)
      SZ_B: begin
        keep = KEEP_B;
        sign = lane[7];
      end
      SZ_H: begin
        keep    = KEEP_H;
        sign    = lane[15];
        ext_err = addr_lo[0];
      end
      SZ_W: begin
        keep    = KEEP_W;
        sign    = lane[31];
        ext_err = (addr_lo[1:0] != 2'b00);
      end
      default: begin
        // Covers LD and the reserved 111 encoding.
        keep    = '1;
        sign    = 1'b0;
        ext_err = uns || (DATA_W == 32) || (addr_lo != '0);
      end
    endcase

    if (ext_err) begin
      ext_data = '0;
    end else if (sz == SZ_D) begin
      ext_data = rdata;
    end else begin
      ext_data = (lane & keep) | ((sign && !uns) ? ~keep : '0);
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign en        = out_ready | ~out_valid;
  assign in_ready  = en & ~flush;
  assign accept    = in_valid & in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && ext_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        vld_q <= '0;
      end else if (en) begin
        vld_q[0] <= accept;
        for (int unsigned i = 1; i < STAGES; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
      // Payload moves with en even during flush; the output gating hides it.
      if (en) begin
        data_q[0] <= ext_data;
        err_q[0]  <= ext_err;
        tag_q[0]  <= in_tag;
        for (int unsigned i = 1; i < STAGES; i++) begin
          data_q[i] <= data_q[i-1];
          err_q[i]  <= err_q[i-1];
          tag_q[i]  <= tag_q[i-1];
        end
      end
    end
  end

  assign out_data = out_valid ? data_q[STAGES-1] : '0;
  assign out_err  = out_valid ? err_q[STAGES-1]  : 1'b0;
  assign out_tag  = out_valid ? tag_q[STAGES-1]  : '0;
  assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_load_ext_pipe.sv
// Directed bench for load_ext_pipe: four instances cover 32/64-bit lanes,
// deep-pipeline stalls, flush behaviour and counter saturation.
module tb_load_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  // a: DATA_W=32, STAGES=1
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [31:0] a_rdata, a_out_data;
  logic [1:0]  a_addr;
  logic [2:0]  a_mode;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [7:0]  a_err_cnt;

  // b: DATA_W=64, STAGES=1
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [63:0] b_rdata, b_out_data;
  logic [2:0]  b_addr;
  logic [2:0]  b_mode;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [7:0]  b_err_cnt;

  // c: DATA_W=32, STAGES=3
  logic        c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [31:0] c_rdata, c_out_data;
  logic [1:0]  c_addr;
  logic [2:0]  c_mode;
  logic [4:0]  c_in_tag, c_out_tag;
  logic [7:0]  c_err_cnt;

  // d: DATA_W=32, STAGES=2, CNT_W=2
  logic        d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_err;
  logic [31:0] d_rdata, d_out_data;
  logic [1:0]  d_addr;
  logic [2:0]  d_mode;
  logic [4:0]  d_in_tag, d_out_tag;
  logic [1:0]  d_err_cnt;

  load_ext_pipe #(.DATA_W(32), .STAGES(1), .TAG_W(5), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rdata(a_rdata), .addr_lo(a_addr), .mode(a_mode), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_err(a_out_err), .out_tag(a_out_tag), .err_cnt(a_err_cnt));

  load_ext_pipe #(.DATA_W(64), .STAGES(1), .TAG_W(5), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rdata(b_rdata), .addr_lo(b_addr), .mode(b_mode), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_err(b_out_err), .out_tag(b_out_tag), .err_cnt(b_err_cnt));

  load_ext_pipe #(.DATA_W(32), .STAGES(3), .TAG_W(5), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .rdata(c_rdata), .addr_lo(c_addr), .mode(c_mode), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_err(c_out_err), .out_tag(c_out_tag), .err_cnt(c_err_cnt));

  load_ext_pipe #(.DATA_W(32), .STAGES(2), .TAG_W(5), .CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .rdata(d_rdata), .addr_lo(d_addr), .mode(d_mode), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data),
    .out_err(d_out_err), .out_tag(d_out_tag), .err_cnt(d_err_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_rdata = '0; a_addr = '0; a_mode = '0; a_in_tag = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_rdata = '0; b_addr = '0; b_mode = '0; b_in_tag = '0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_rdata = '0; c_addr = '0; c_mode = '0; c_in_tag = '0;
    d_flush = 0; d_in_valid = 0; d_out_ready = 0; d_rdata = '0; d_addr = '0; d_mode = '0; d_in_tag = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
    compared++;
    if ({a_in_ready, a_out_valid, a_out_err, a_out_data, a_out_tag, a_err_cnt} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL reset_a: got rdy=%b v=%b e=%b d=%h t=%h c=%h want rdy=1 rest 0", a_in_ready, a_out_valid, a_out_err, a_out_data, a_out_tag, a_err_cnt);
    end
    compared++;
    if ({b_in_ready, b_out_valid, b_out_err, b_out_data, b_out_tag, b_err_cnt} !== {1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL reset_b: got rdy=%b v=%b e=%b d=%h t=%h c=%h want rdy=1 rest 0", b_in_ready, b_out_valid, b_out_err, b_out_data, b_out_tag, b_err_cnt);
    end
    compared++;
    if ({c_in_ready, c_out_valid, c_out_err, c_out_data, c_out_tag, c_err_cnt} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 8'd0}) begin
      mismatched++;
      $display("FAIL reset_c: got rdy=%b v=%b e=%b d=%h t=%h c=%h want rdy=1 rest 0", c_in_ready, c_out_valid, c_out_err, c_out_data, c_out_tag, c_err_cnt);
    end
    compared++;
    if ({d_in_ready, d_out_valid, d_out_err, d_out_data, d_out_tag, d_err_cnt} !== {1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 2'd0}) begin
      mismatched++;
      $display("FAIL reset_d: got rdy=%b v=%b e=%b d=%h t=%h c=%h want rdy=1 rest 0", d_in_ready, d_out_valid, d_out_err, d_out_data, d_out_tag, d_err_cnt);
    end
  endtask

  // Vectors on the 32-bit single-stage instance, streamed back to back.
  task automatic test_ext32();
    logic [31:0] want_d [8];
    logic        want_e [8];
    logic [31:0] vec_rd [8];
    logic [1:0]  vec_ad [8];
    logic [2:0]  vec_md [8];
    logic [7:0]  want_c [8];
    vec_rd = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD, 32'h8001ABCD};
    vec_ad = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0};
    vec_md = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b011};
    want_d = '{32'h0000007F, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0, 32'h8001ABCD, 32'h0};
    want_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    want_c = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    a_out_ready = 1;
    a_in_valid  = 1;
    for (int i = 0; i < 8; i++) begin
      a_rdata = vec_rd[i]; a_addr = vec_ad[i]; a_mode = vec_md[i]; a_in_tag = 5'(i + 3);
      tick();
      compared++;
      if ({a_out_valid, a_out_err, a_out_data, a_out_tag, a_err_cnt} !== {1'b1, want_e[i], want_d[i], 5'(i + 3), want_c[i]}) begin
        mismatched++;
        $display("FAIL ext32_%0d: got v=%b e=%b d=%h t=%0d c=%0d want v=1 e=%b d=%h t=%0d c=%0d",
                 i, a_out_valid, a_out_err, a_out_data, a_out_tag, a_err_cnt, want_e[i], want_d[i], i + 3, want_c[i]);
      end
    end
    a_in_valid = 0;
    tick();
    compared++;
    if ({a_out_valid, a_out_err, a_out_data, a_out_tag} !== {1'b0, 1'b0, 32'h0, 5'd0}) begin
      mismatched++;
      $display("FAIL ext32_idle: got v=%b e=%b d=%h t=%h want all 0", a_out_valid, a_out_err, a_out_data, a_out_tag);
    end
  endtask

  task automatic test_ext64();
    logic [63:0] want_d [5];
    logic        want_e [5];
    logic [2:0]  vec_ad [5];
    logic [2:0]  vec_md [5];
    vec_ad = '{3'd4, 3'd4, 3'd0, 3'd4, 3'd7};
    vec_md = '{3'b010, 3'b110, 3'b011, 3'b011, 3'b000};
    want_d = '{64'hFFFFFFFF89ABCDEF, 64'h0000000089ABCDEF, 64'h89ABCDEF01234567, 64'h0, 64'hFFFFFFFFFFFFFF89};
    want_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    b_rdata     = 64'h89ABCDEF01234567;
    b_out_ready = 1;
    b_in_valid  = 1;
    for (int i = 0; i < 5; i++) begin
      b_addr = vec_ad[i]; b_mode = vec_md[i]; b_in_tag = 5'(i + 10);
      tick();
      compared++;
      if ({b_out_valid, b_out_err, b_out_data, b_out_tag} !== {1'b1, want_e[i], want_d[i], 5'(i + 10)}) begin
        mismatched++;
        $display("FAIL ext64_%0d: got v=%b e=%b d=%h t=%0d want v=1 e=%b d=%h t=%0d",
                 i, b_out_valid, b_out_err, b_out_data, b_out_tag, want_e[i], want_d[i], i + 10);
      end
    end
    b_in_valid = 0;
    tick();
    compared++;
    if (b_err_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL ext64_cnt: got %0d want 1", b_err_cnt);
    end
  endtask

  // Five beats through three stages with a four-cycle downstream stall.
  task automatic test_stall();
    int sent = 0;
    int got  = 0;
    c_mode = 3'b010;
    c_addr = 2'd0;
    for (int cyc = 1; cyc <= 30 && got < 5; cyc++) begin
      c_out_ready = !(cyc >= 4 && cyc <= 7);
      c_in_valid  = (sent < 5);
      c_in_tag    = 5'(sent + 1);
      c_rdata     = 32'(sent + 1);
      #1;
      if (cyc == 3) begin
        compared++;
        if (c_out_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_latency: out_valid=%b before third edge, want 0", c_out_valid);
        end
      end
      if (!c_out_ready) begin
        compared++;
        if ({c_in_ready, c_out_valid, c_out_data, c_out_tag} !== {1'b0, 1'b1, 32'd1, 5'd1}) begin
          mismatched++;
          $display("FAIL stall_hold_c%0d: got rdy=%b v=%b d=%h t=%0d want rdy=0 v=1 d=1 t=1",
                   cyc, c_in_ready, c_out_valid, c_out_data, c_out_tag);
        end
      end
      if (c_out_valid && c_out_ready) begin
        compared++;
        if ({c_out_err, c_out_data, c_out_tag} !== {1'b0, 32'(got + 1), 5'(got + 1)}) begin
          mismatched++;
          $display("FAIL stall_order: got e=%b d=%h t=%0d want e=0 d=%0d t=%0d", c_out_err, c_out_data, c_out_tag, got + 1, got + 1);
        end
        got++;
      end
      if (c_in_valid && c_in_ready) sent++;
      tick();
    end
    compared++;
    if (sent != 5 || got != 5) begin
      mismatched++;
      $display("FAIL stall_count: sent=%0d delivered=%0d want 5/5", sent, got);
    end
    c_in_valid = 0;
    tick();
    compared++;
    if (c_out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_dup: out_valid=%b tag=%0d after stream, want 0", c_out_valid, c_out_tag);
    end
  endtask

  task automatic test_flush();
    d_out_ready = 1;
    d_in_valid  = 1;
    d_mode      = 3'b010;
    d_addr      = 2'd0;
    d_in_tag    = 5'd7; d_rdata = 32'h77;
    tick();
    d_in_tag    = 5'd8; d_rdata = 32'h88;
    tick();
    compared++;
    if ({d_out_valid, d_out_data, d_out_tag} !== {1'b1, 32'h77, 5'd7}) begin
      mismatched++;
      $display("FAIL flush_pre: got v=%b d=%h t=%0d want v=1 d=77 t=7", d_out_valid, d_out_data, d_out_tag);
    end
    d_flush  = 1;
    d_mode   = 3'b111;
    d_in_tag = 5'd9;
    #1;
    compared++;
    if (d_in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_ready: got in_ready=%b want 0", d_in_ready);
    end
    tick();
    d_flush    = 0;
    d_in_valid = 0;
    #1;
    compared++;
    if ({d_out_valid, d_out_err, d_out_data, d_out_tag, d_err_cnt} !== {1'b0, 1'b0, 32'h0, 5'd0, 2'd0}) begin
      mismatched++;
      $display("FAIL flush_post: got v=%b e=%b d=%h t=%0d c=%0d want all 0", d_out_valid, d_out_err, d_out_data, d_out_tag, d_err_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (d_out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_ghost_%0d: got out_valid=%b tag=%0d want 0", i, d_out_valid, d_out_tag);
      end
    end
  endtask

  task automatic test_err_cnt();
    logic [1:0] want_c [5];
    want_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    d_out_ready = 1;
    d_in_valid  = 1;
    d_mode      = 3'b111;
    d_rdata     = 32'hDEADBEEF;
    d_in_tag    = 5'd21;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (d_err_cnt !== want_c[i]) begin
        mismatched++;
        $display("FAIL errcnt_%0d: got %0d want %0d", i, d_err_cnt, want_c[i]);
      end
    end
    compared++;
    if ({d_out_valid, d_out_err, d_out_data, d_out_tag} !== {1'b1, 1'b1, 32'h0, 5'd21}) begin
      mismatched++;
      $display("FAIL errcnt_beat: got v=%b e=%b d=%h t=%0d want v=1 e=1 d=0 t=21", d_out_valid, d_out_err, d_out_data, d_out_tag);
    end
    rst     = 1;
    d_flush = 1;
    tick();
    rst        = 0;
    d_flush    = 0;
    d_in_valid = 0;
    #1;
    compared++;
    if ({d_out_valid, d_out_err, d_out_data, d_out_tag, d_err_cnt} !== {1'b0, 1'b0, 32'h0, 5'd0, 2'd0}) begin
      mismatched++;
      $display("FAIL errcnt_rst: got v=%b e=%b d=%h t=%0d c=%0d want all 0", d_out_valid, d_out_err, d_out_data, d_out_tag, d_err_cnt);
    end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_ext32();
    test_ext64();
    test_stall();
    test_flush();
    test_err_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
